muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS execute stage. It consumes the same two register operands that feed the ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results go into architectural HI/LO registers, which the pipeline reads back for MFHI/MFLO. A start/busy/done handshake lets the pipeline stall while a 32-step operation is in flight.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions.
// Mul/div op encodings, FSM state codes and operand helpers.
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// acc holds {partial, multiplier} or {remainder, dividend/quotient}.
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opb,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] r33;
  logic [31:0] rsub;
  logic        ge;

  always_comb begin
    sum  = {1'b0, acc[63:32]} + {1'b0, opb};
    r33  = acc[63:31];
    // true difference fits in 32 bits whenever ge is set
    rsub = r33[31:0] - opb;
    ge   = r33 >= {1'b0, opb};
    acc_next = acc;
    if (is_div) begin
      if (ge) acc_next = {rsub, acc[30:0], 1'b1};
      else    acc_next = {r33[31:0], acc[30:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[31:1]};
    end else begin
      acc_next = {1'b0, acc[63:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// 32 RUN cycles plus one FIX cycle for sign correction.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [31:0] opb;
  logic [31:0] raw0;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div0;

  logic        is_md;
  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  muldiv_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opb      (opb),
    .acc_next (acc_next)
  );

  always_comb begin
    is_md = !op[2];
    sgn   = (op == MD_MULT) || (op == MD_DIV);
    a_neg = sgn && in0[31];
    b_neg = sgn && in1[31];
    prod  = neg_res ? -acc : acc;
    quo   = neg_res ? -acc[31:0] : acc[31:0];
    rem   = neg_rem ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      cnt     <= 5'd0;
      acc     <= 64'd0;
      opb     <= 32'd0;
      raw0    <= 32'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        MD_IDLE: begin
          if (start && !flush) begin
            unique case (1'b1)
              is_md: begin
                is_div  <= op[1];
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                div0    <= op[1] && (in1 == 32'd0);
                raw0    <= in0;
                cnt     <= 5'd0;
                busy    <= 1'b1;
                state   <= MD_RUN;
                if (op[1]) begin
                  acc <= {32'd0, mag(in0, sgn)};
                  opb <= mag(in1, sgn);
                end else begin
                  acc <= {32'd0, mag(in1, sgn)};
                  opb <= mag(in0, sgn);
                end
              end
              (op == MD_MTHI): hi <= in0;
              (op == MD_MTLO): lo <= in0;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          if (flush) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= MD_FIX;
          end
        end
        MD_FIX: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (div0) begin
              hi <= raw0;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in0   (in0),
    .in1   (in1),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start in the current cycle T; dcyc is the offset of the done cycle
  task automatic do_op(
    input  logic [2:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          bcnt,
    output int          dcyc
  );
    op = o; in0 = a; in1 = b; start = 1'b1;
    step();
    start = 1'b0;
    bcnt = 0;
    dcyc = -1;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        dcyc = k;
        break;
      end
      if (busy) bcnt++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; flush = 1'b0;
    op = 3'd0; in0 = 32'd0; in1 = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_lo got %h want 0", lo); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int bc, dc;
    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, bc, dc);
    checks++; if (dc !== 34) begin errors++; $display("FAIL mult_lat got %0d want 34", dc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done got %b want 0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", done); end
  endtask

  task automatic test_multu();
    int bc, dc;
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy got %0d want 33", bc); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 1", lo); end
    step();
  endtask

  task automatic test_div();
    int bc, dc;
    do_op(MD_DIVU, 32'd100, 32'd7, bc, dc);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 2", hi); end
    step();
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, bc, dc);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    step();
    do_op(MD_DIVU, 32'h1234, 32'd0, bc, dc);
    checks++; if (dc !== 34) begin errors++; $display("FAIL div0_lat got %0d want 34", dc); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", lo); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL div0_hi got %h want 1234", hi); end
    step();
    do_op(MD_DIV, 32'hFFFF_FFF0, 32'd0, bc, dc);
    checks++; if (hi !== 32'hFFFF_FFF0) begin errors++; $display("FAIL sdiv0_hi got %h want fffffff0", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv0_lo got %h want ffffffff", lo); end
    step();
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got %h want 0", hi); end
    step();
  endtask

  task automatic test_ignore_busy();
    int dc;
    op = MD_MULT; in0 = 32'd5; in1 = 32'd6; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    in0 = 32'd9; in1 = 32'd11; start = 1'b1;
    step();
    start = 1'b0;
    dc = -1;
    for (int k = 6; k <= 60; k++) begin
      if (done) begin
        dc = k;
        break;
      end
      step();
    end
    checks++; if (dc !== 34) begin errors++; $display("FAIL ign_lat got %0d want 34", dc); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ign_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd30) begin errors++; $display("FAIL ign_lo got %h want 1e", lo); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_second got %b want 0", busy); end
  endtask

  task automatic test_mthi_mtlo();
    op = MD_MTHI; in0 = 32'hDEAD_BEEF; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi got %h want deadbeef", hi); end
    checks++; if (lo !== 32'd30) begin errors++; $display("FAIL mthi_lo got %h want 1e", lo); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mthi_hs got %b%b want 00", busy, done); end
    op = MD_MTLO; in0 = 32'hCAFE_F00D; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_lo got %h want cafef00d", lo); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mtlo_hs got %b%b want 00", busy, done); end
  endtask

  task automatic test_flush();
    int seen;
    op = MD_MULT; in0 = 32'd3; in1 = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_quiet got %0d want 0", seen); end
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flush_hi got %h want deadbeef", hi); end
    checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL flush_lo got %h want cafef00d", lo); end
  endtask

  task automatic test_idle_ignore();
    op = MD_MTHI; in0 = 32'h1; start = 1'b1; flush = 1'b1;
    step();
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flushst_hi got %h want deadbeef", hi); end
    op = MD_MULT; in0 = 32'd2; in1 = 32'd2;
    step();
    flush = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flushst_busy got %b want 0", busy); end
    op = 3'd6; in0 = 32'h55; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL undef_busy got %b want 0", busy); end
    checks++; if (hi !== 32'hDEAD_BEEF || lo !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL undef_hilo got %h_%h want deadbeef_cafef00d", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int bc, dc;
    do_op(MD_MULTU, 32'd3, 32'd4, bc, dc);
    checks++; if (lo !== 32'd12 || hi !== 32'd0) begin errors++; $display("FAIL b2b_first got %h_%h want 0_c", hi, lo); end
    do_op(MD_DIVU, 32'd100, 32'd7, bc, dc);
    checks++; if (dc !== 34) begin errors++; $display("FAIL b2b_lat got %0d want 34", dc); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL b2b_second got %h_%h want 2_e", hi, lo); end
    step();
  endtask

  task automatic test_reset_mid();
    op = MD_MULT; in0 = 32'd7; in1 = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    rst_n = 1'b0;
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got %h_%h want 0_0", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    step();
    rst_n = 1'b1;
    repeat (20) step();
    checks++; if (done !== 1'b0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_discard got %b_%h want 0_0", done, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_ignore_busy();
    test_mthi_mtlo();
    test_flush();
    test_idle_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
